mem_req_ctrl: RTL and testbench

Upstream request controller for the 16x32 Memory block. It accepts write/read commands on a valid/ready interface and drives the Memory's EN/wr_en/rd_en/add/Data_in pins with one-cycle strobes. It captures valid_out/Data_out into a held response with valid/ready. It allows one outstanding operation, times out reads that never return, and reports status to the environment.

---
 rtl/mem_req_ctrl_pkg.sv | 36 +++
 rtl/mem_req_ctrl_if.sv | 62 ++++++
 rtl/mem_req_ctrl_rsp_hold.sv | 54 +++++
 rtl/mem_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and defaults for the memory request controller.
//               It provides the controller state encoding, the default bus
//               widths and a command record.
// Macro       : INIT_SWEEP_EN adds the ST_INIT state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_ctrl_pkg;

    localparam int c_DEF_ADDR_WIDTH = 4;
    localparam int c_DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_RESP      = 3'd4
`ifdef INIT_SWEEP_EN
        ,ST_INIT     = 3'd5
`endif
    } ctrl_state_t;

    typedef struct packed {
        logic                        write;
        logic [c_DEF_ADDR_WIDTH-1:0] add;
        logic [c_DEF_DATA_WIDTH-1:0] data;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_ctrl_if.sv
// ============================================================================
// Module      : mem_req_ctrl_if
// Description : Bundle of the command, memory-pin and response channels of
//               the memory request controller.
//               master : environment side (issues commands, models memory,
//                        consumes responses)
//               slave  : controller side
// Ports       : cmd_*  command valid/ready channel
//               mem_*  pins toward the 16x32 Memory block
//               rsp_*  held read response valid/ready channel
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_req_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_add;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic                  mem_EN;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_add;
    logic [DATA_WIDTH-1:0] mem_Data_in;
    logic                  mem_valid_out;
    logic [DATA_WIDTH-1:0] mem_Data_out;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_add;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_add, cmd_data,
        input  cmd_ready,
        input  mem_EN, mem_wr_en, mem_rd_en, mem_add, mem_Data_in,
        output mem_valid_out, mem_Data_out,
        input  rsp_valid, rsp_data, rsp_add, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_add, cmd_data,
        output cmd_ready,
        output mem_EN, mem_wr_en, mem_rd_en, mem_add, mem_Data_in,
        input  mem_valid_out, mem_Data_out,
        output rsp_valid, rsp_data, rsp_add, rsp_err,
        input  rsp_ready
    );

endinterface

`default_nettype wire

// File: rtl/mem_req_ctrl_rsp_hold.sv
// ============================================================================
// Module      : mem_rsp_hold
// Description : Read-response holding register with a valid/ready output.
//               A load captures data/address/error and raises valid; the
//               fields stay stable until the consumer accepts with ready.
//               A load flagged as an error captures zero data.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_load, i_err       capture strobe and timeout flag
//               i_data, i_add       read data and address to capture
//               i_ready             consumer accepts the held response
//               o_valid, o_data,
//               o_add, o_err        held response
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_rsp_hold #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_err,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_add,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_add,
    output logic                  o_err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_add   <= '0;
            o_err   <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_err ? '0 : i_data;
            o_add   <= i_add;
            o_err   <= i_err;
        end else if (o_valid && i_ready) begin
            // Fields are left as-is after acceptance; only valid drops.
            o_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_req_ctrl.sv
// ============================================================================
// Module      : mem_req_ctrl
// Description : Upstream request controller for the 16x32 Memory block.
//               Accepts one write/read command at a time, issues one-cycle
//               memory strobes, waits for read data with a bounded timeout
//               and presents a held response.
// Ports       : clk, rst     clock, synchronous active-high reset
//               bus (slave)  cmd_*, mem_*, rsp_* channels
//               busy         controller not idle
//               err_timeout  sticky read-timeout flag, cleared by rst only
// Macro       : INIT_SWEEP_EN - after reset, write zero to every address
//               before accepting commands.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int RD_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_req_ctrl_if.slave bus,
    output logic          busy,
    output logic          err_timeout
);

    localparam int                 c_CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RD_TIMEOUT - 1);
`ifdef INIT_SWEEP_EN
    localparam ctrl_state_t        c_RST_STATE = ST_INIT;
`else
    localparam ctrl_state_t        c_RST_STATE = ST_IDLE;
`endif

    ctrl_state_t           r_state;
    ctrl_state_t           w_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_add;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err_timeout;
    logic                  w_hs;
    logic                  w_rsp_load;
    logic                  w_rsp_err;
    logic                  w_in_init;
    logic                  w_init_wr;

    assign bus.cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign w_hs          = bus.cmd_valid & bus.cmd_ready;

`ifdef INIT_SWEEP_EN
    logic [ADDR_WIDTH-1:0] r_sweep;

    assign w_in_init = (r_state == ST_INIT);
    // The reset state is INIT, so its write strobe is masked while rst is held.
    assign w_init_wr = w_in_init & ~rst;

    always_ff @(posedge clk) begin
        if (rst)            r_sweep <= '0;
        else if (w_in_init) r_sweep <= r_sweep + 1'b1;
    end

    assign bus.mem_add = w_in_init ? r_sweep : r_add;
`else
    assign w_in_init   = 1'b0;
    assign w_init_wr   = 1'b0;
    assign bus.mem_add = r_add;
`endif

    // Strobes decode straight from the state register; address/data come
    // from registers that change only on a handshake, so they hold otherwise.
    assign bus.mem_EN      = (r_state == ST_WRITE) | (r_state == ST_READ) | w_init_wr;
    assign bus.mem_wr_en   = (r_state == ST_WRITE) | w_init_wr;
    assign bus.mem_rd_en   = (r_state == ST_READ);
    assign bus.mem_Data_in = r_data;

    assign busy        = ((r_state != ST_IDLE) & ~w_in_init) | w_init_wr;
    assign err_timeout = r_err_timeout;

    always_comb begin
        w_next     = r_state;
        w_rsp_load = 1'b0;
        w_rsp_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) w_next = bus.cmd_write ? ST_WRITE : ST_READ;
            end
            ST_WRITE: w_next = ST_IDLE;
            ST_READ:  w_next = ST_READ_WAIT;
            ST_READ_WAIT: begin
                // Data arriving on the final count still wins over timeout.
                if (bus.mem_valid_out) begin
                    w_rsp_load = 1'b1;
                    w_next     = ST_RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_rsp_load = 1'b1;
                    w_rsp_err  = 1'b1;
                    w_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) w_next = ST_IDLE;
            end
`ifdef INIT_SWEEP_EN
            ST_INIT: begin
                if (r_sweep == {ADDR_WIDTH{1'b1}}) w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_RST_STATE;
            r_cnt         <= '0;
            r_add         <= '0;
            r_data        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_add <= bus.cmd_add;
                // Read commands leave the write-data pins untouched.
                if (bus.cmd_write) r_data <= bus.cmd_data;
            end
            if (r_state == ST_READ)
                r_cnt <= '0;
            else if ((r_state == ST_READ_WAIT) && !bus.mem_valid_out && (r_cnt != c_CNT_LAST))
                r_cnt <= r_cnt + 1'b1;
            if (w_rsp_load && w_rsp_err) r_err_timeout <= 1'b1;
        end
    end

    mem_rsp_hold #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rsp_load),
        .i_err   (w_rsp_err),
        .i_data  (bus.mem_Data_out),
        .i_add   (r_add),
        .i_ready (bus.rsp_ready),
        .o_valid (bus.rsp_valid),
        .o_data  (bus.rsp_data),
        .o_add   (bus.rsp_add),
        .o_err   (bus.rsp_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
// ============================================================================
// Module      : tb_mem_req_ctrl
// Description : Self-checking bench for mem_req_ctrl. A behavioural memory
//               answers read strobes after a programmable latency. Directed
//               table vectors, hand sequences and random traffic are checked
//               against a shadow-memory model and the timeout rule.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_req_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    logic [DW-1:0] mem_arr [16];
    int            mem_lat;
    bit            mem_drop;
    bit            spur_req;
    bit            pend;
    int            pend_cnt;
    logic [DW-1:0] pend_data;

    always @(posedge clk) begin
        bit hit;
        hit = pend && (pend_cnt == 0);
        bus.mem_valid_out <= hit | spur_req;
        bus.mem_Data_out  <= hit ? pend_data : 32'hBAD0_BAD0;
        if (bus.mem_EN === 1'b1 && bus.mem_wr_en === 1'b1) mem_arr[bus.mem_add] <= bus.mem_Data_in;
        if (bus.mem_EN === 1'b1 && bus.mem_rd_en === 1'b1) begin
            pend      <= !mem_drop;
            pend_cnt  <= mem_lat;
            pend_data <= mem_arr[bus.mem_add];
        end else if (pend) begin
            if (hit) pend <= 1'b0;
            else     pend_cnt <= pend_cnt - 1;
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] shadow [16];
    bit            m_sticky;

    typedef struct {
        cmd_t        cmd;
        int          lat;
        int          rdy;
        logic [31:0] exp_data;
        bit          exp_err;
        bit          exp_sticky;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " cmd_ready"}, bus.cmd_ready, 1);
    endtask

    task automatic do_write(input string nm, input logic [3:0] a, input logic [31:0] d);
        wait_ready(nm);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_add = a; bus.cmd_data = d;
        @(posedge clk); #1 bus.cmd_valid = 1'b0; bus.cmd_data = $urandom;
        @(negedge clk);
        chk({nm, " wr strobes"}, {bus.mem_EN, bus.mem_wr_en, bus.mem_rd_en}, 3'b110);
        chk({nm, " wr add"}, bus.mem_add, a);
        chk({nm, " wr data"}, bus.mem_Data_in, d);
        chk({nm, " wr busy/ready"}, {busy, bus.cmd_ready}, 2'b10);
        @(negedge clk);
        chk({nm, " post-wr strobes"}, {bus.mem_EN, bus.mem_wr_en, bus.mem_rd_en, busy}, 4'b0000);
        chk({nm, " post-wr hold"}, {bus.mem_add, bus.mem_Data_in}, {a, d});
        shadow[a] = d;
    endtask

    task automatic do_read(input string nm, input logic [3:0] a, input int lat, input int rdy,
                           input logic [31:0] ed, input bit ee, input bit es);
        int n;
        bit strobe_seen;
        wait_ready(nm);
        mem_lat  = lat;
        mem_drop = (lat > TMO - 2);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_add = a; bus.cmd_data = $urandom;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk({nm, " rd strobes"}, {bus.mem_EN, bus.mem_wr_en, bus.mem_rd_en}, 3'b101);
        chk({nm, " rd add"}, bus.mem_add, a);
        n = 0;
        strobe_seen = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid !== 1'b1 && bus.mem_EN !== 1'b0) strobe_seen = 1'b1;
        end
        // Edges from handshake to visible response: READ, then either the
        // memory latency plus sampling, or the full timeout window.
        chk({nm, " rsp latency"}, n, (lat <= TMO - 2) ? lat + 3 : TMO + 1);
        chk({nm, " strobes idle in wait"}, strobe_seen, 0);
        for (int i = 0; i < rdy; i++) begin
            chk({nm, " hold data"}, {bus.rsp_data, bus.rsp_add, bus.rsp_err}, {ed, a, ee});
            chk({nm, " hold ready"}, {bus.rsp_valid, bus.cmd_ready}, 2'b10);
            @(negedge clk);
        end
        chk({nm, " rsp_valid"}, bus.rsp_valid, 1);
        chk({nm, " rsp_data"}, bus.rsp_data, ed);
        chk({nm, " rsp_add"}, bus.rsp_add, a);
        chk({nm, " rsp_err"}, bus.rsp_err, ee);
        chk({nm, " err_timeout"}, err_timeout, es);
        chk({nm, " busy/ready in resp"}, {busy, bus.cmd_ready}, 2'b10);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, " after accept"}, {bus.rsp_valid, busy, bus.cmd_ready}, 3'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen_rsp;
        bit   seen_mv;
        logic [3:0]  a;
        logic [31:0] d;
        int   lat;
        bit   ok;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_add = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;
        mem_lat = 0; mem_drop = 1'b0; spur_req = 1'b0;

        tbl[0]  = '{'{1'b1, 4'h3, 32'hDEADBEEF}, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1]  = '{'{1'b1, 4'h5, 32'h12345678}, 0, 0, 32'h12345678, 1'b0, 1'b0};
        tbl[2]  = '{'{1'b0, 4'h5, 32'h0},        0, 0, 32'h12345678, 1'b0, 1'b0};
        tbl[3]  = '{'{1'b0, 4'h5, 32'h0},        2, 4, 32'h12345678, 1'b0, 1'b0};
        tbl[4]  = '{'{1'b1, 4'hA, 32'h0F0F0F0F}, 0, 0, 32'h0F0F0F0F, 1'b0, 1'b0};
        tbl[5]  = '{'{1'b0, 4'h3, 32'h0},        6, 1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[6]  = '{'{1'b0, 4'hA, 32'h0},        7, 0, 32'h00000000, 1'b1, 1'b1};
        tbl[7]  = '{'{1'b0, 4'hA, 32'h0},        1, 2, 32'h0F0F0F0F, 1'b0, 1'b1};
        tbl[8]  = '{'{1'b1, 4'h5, 32'hCAFEF00D}, 0, 0, 32'hCAFEF00D, 1'b0, 1'b1};
        tbl[9]  = '{'{1'b0, 4'h5, 32'h0},        9, 3, 32'h00000000, 1'b1, 1'b1};
        tbl[10] = '{'{1'b0, 4'h5, 32'h0},        0, 0, 32'hCAFEF00D, 1'b0, 1'b1};

        // ---- reset held three cycles ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs",
            {busy, err_timeout, bus.mem_EN, bus.mem_wr_en, bus.mem_rd_en, bus.mem_add,
             bus.mem_Data_in, bus.rsp_valid, bus.rsp_data, bus.rsp_add, bus.rsp_err}, '0);
        chk("reset cmd_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
`ifdef INIT_SWEEP_EN
        chk("sweep busy", {busy, bus.cmd_ready, bus.mem_wr_en}, 3'b101);
        repeat (15) @(negedge clk);
`endif
        chk("first ready after reset", {bus.cmd_ready, busy}, 2'b10);

        // ---- directed vectors ----
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (tbl[i].cmd.write)
                do_write(nm, tbl[i].cmd.add, tbl[i].cmd.data);
            else
                do_read(nm, tbl[i].cmd.add, tbl[i].lat, tbl[i].rdy,
                        tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_sticky);
        end

        // ---- stray memory valid and rsp_ready while idle ----
        wait_ready("stray");
        spur_req = 1'b1; bus.rsp_ready = 1'b1;
        @(posedge clk); #1 spur_req = 1'b0;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("stray ignored", {bus.rsp_valid, busy, bus.cmd_ready}, 3'b001);

        // ---- reset while waiting for read data ----
        wait_ready("rstrw");
        mem_lat = 3; mem_drop = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_add = 4'h5;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstrw outputs", {bus.mem_EN, bus.mem_rd_en, busy, bus.rsp_valid, bus.cmd_ready}, 5'b0);
        chk("rstrw sticky cleared", err_timeout, 0);
        rst = 1'b0;
        seen_rsp = 1'b0;
        seen_mv  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen_rsp = 1'b1;
            if (bus.mem_valid_out === 1'b1) seen_mv = 1'b1;
        end
        chk("rstrw late valid arrived", seen_mv, 1);
        chk("rstrw no response", seen_rsp, 0);
`ifndef INIT_SWEEP_EN
        chk("rstrw idle", {bus.cmd_ready, busy}, 2'b10);
`endif

        // ---- random traffic against shadow model ----
        m_sticky = 1'b0;
        for (int k = 0; k < 16; k++) do_write($sformatf("fill%0d", k), 4'(k), $urandom);
        for (int k = 0; k < 40; k++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write($sformatf("rnd%0d", k), a, d);
            end else begin
                lat = $urandom_range(0, 9);
                ok  = (lat <= TMO - 2);
                m_sticky = m_sticky | !ok;
                do_read($sformatf("rnd%0d", k), a, lat, $urandom_range(0, 3),
                        ok ? shadow[a] : 32'h0, !ok, m_sticky);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
